// File: rtl/alu_sys_pkg.sv
// Shared ALU-system definitions: command-controller FSM states, frame bytes
// and the ALU function-code map.
package alu_sys_pkg;

   localparam logic [7:0] CMD_ALU  = 8'hCC;
   localparam logic [7:0] ERR_BYTE = 8'hEE;

   localparam logic [3:0] FUN_ADD   = 4'd0;
   localparam logic [3:0] FUN_SUB   = 4'd1;
   localparam logic [3:0] FUN_MUL   = 4'd2;
   localparam logic [3:0] FUN_DIV   = 4'd3;
   localparam logic [3:0] FUN_AND   = 4'd4;
   localparam logic [3:0] FUN_OR    = 4'd5;
   localparam logic [3:0] FUN_NAND  = 4'd6;
   localparam logic [3:0] FUN_NOR   = 4'd7;
   localparam logic [3:0] FUN_XOR   = 4'd8;
   localparam logic [3:0] FUN_XNOR  = 4'd9;
   localparam logic [3:0] FUN_CMPEQ = 4'd10;
   localparam logic [3:0] FUN_CMPGT = 4'd11;
   localparam logic [3:0] FUN_CMPLT = 4'd12;
   localparam logic [3:0] FUN_SHR   = 4'd13;
   localparam logic [3:0] FUN_SHL   = 4'd14;

   typedef enum logic [3:0] {
      IDLE,
      GET_A,
      GET_B,
      GET_FUN,
      EXEC,
      WAIT,
      TX_LO,
      TX_HI,
      TX_ERR
   } ctrl_state_e;

   function automatic logic is_rx_state(input ctrl_state_e s);
      return (s == GET_A) || (s == GET_B) || (s == GET_FUN);
   endfunction

   function automatic logic is_tx_state(input ctrl_state_e s);
      return (s == TX_LO) || (s == TX_HI) || (s == TX_ERR);
   endfunction

endpackage

// File: rtl/alu_cmd_ctrl_if.sv
// Bus bundle between the command controller and its RX source, TX FIFO and ALU.
// master = controller side, slave = environment side.
interface alu_cmd_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int FUN_WIDTH  = 4
);
   logic [DATA_WIDTH-1:0]   RX_DATA;
   logic                    RX_VALID;
   logic [DATA_WIDTH-1:0]   TX_DATA;
   logic                    TX_VALID;
   logic                    TX_READY;
   logic [DATA_WIDTH-1:0]   ALU_A;
   logic [DATA_WIDTH-1:0]   ALU_B;
   logic [FUN_WIDTH-1:0]    ALU_FUN;
   logic                    ALU_EN;
   logic [2*DATA_WIDTH-1:0] ALU_OUT;
   logic                    ALU_OUT_VALID;
   logic                    BUSY;

   modport master (
      input  RX_DATA, RX_VALID, TX_READY, ALU_OUT, ALU_OUT_VALID,
      output TX_DATA, TX_VALID, ALU_A, ALU_B, ALU_FUN, ALU_EN, BUSY
   );

   modport slave (
      output RX_DATA, RX_VALID, TX_READY, ALU_OUT, ALU_OUT_VALID,
      input  TX_DATA, TX_VALID, ALU_A, ALU_B, ALU_FUN, ALU_EN, BUSY
   );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// ALU command controller: parses CC/A/B/FUN frames, pulses the ALU and returns
// the result (low, high) or an error byte. Optional macro ALU_CMD_TIMEOUT_EN.
module alu_cmd_ctrl
   import alu_sys_pkg::*;
#(
   parameter int                    DATA_WIDTH     = 8,
   parameter int                    FUN_WIDTH      = 4,
   parameter logic [DATA_WIDTH-1:0] CMD_ALU        = DATA_WIDTH'(alu_sys_pkg::CMD_ALU),
   parameter logic [DATA_WIDTH-1:0] ERR_BYTE       = DATA_WIDTH'(alu_sys_pkg::ERR_BYTE),
   parameter int                    TIMEOUT_CYCLES = 255
) (
   input  logic           CLK,
   input  logic           RST_n,
   alu_cmd_ctrl_if.master bus
);

   localparam int RES_W = 2 * DATA_WIDTH;

   ctrl_state_e           state_q, state_d;
   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic [FUN_WIDTH-1:0]  fun_q, fun_d;
   logic [RES_W-1:0]      res_q, res_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  tx_valid_q, tx_valid_d;
   logic                  alu_en_q, alu_en_d;
   logic                  busy_q, busy_d;
   logic                  fun_bad;

`ifdef ALU_CMD_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`else
   logic [31:0] unused_timeout_cfg;
   assign unused_timeout_cfg = TIMEOUT_CYCLES;
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      fun_d   = fun_q;
      res_d   = res_q;
      fun_bad = |bus.RX_DATA[DATA_WIDTH-1:FUN_WIDTH];

      unique case (state_q)
         IDLE: begin
            if (bus.RX_VALID && bus.RX_DATA == CMD_ALU) state_d = GET_A;
         end
         GET_A: begin
            if (bus.RX_VALID) begin
               a_d     = bus.RX_DATA;
               state_d = GET_B;
            end
         end
         GET_B: begin
            if (bus.RX_VALID) begin
               b_d     = bus.RX_DATA;
               state_d = GET_FUN;
            end
         end
         GET_FUN: begin
            if (bus.RX_VALID) begin
               fun_d   = bus.RX_DATA[FUN_WIDTH-1:0];
               state_d = fun_bad ? TX_ERR : EXEC;
            end
         end
         EXEC: state_d = WAIT;
         // ALU result is registered, so valid is due exactly one cycle after EXEC
         WAIT: begin
            if (bus.ALU_OUT_VALID) begin
               res_d   = bus.ALU_OUT;
               state_d = TX_LO;
            end else begin
               state_d = TX_ERR;
            end
         end
         TX_LO:  if (bus.TX_READY) state_d = TX_HI;
         TX_HI:  if (bus.TX_READY) state_d = IDLE;
         TX_ERR: if (bus.TX_READY) state_d = IDLE;
         default: state_d = IDLE;
      endcase

`ifdef ALU_CMD_TIMEOUT_EN
      // An arriving byte always wins over the limit; only silent cycles count
      cnt_d = '0;
      if (is_rx_state(state_q) && !bus.RX_VALID) begin
         if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) state_d = IDLE;
         else                                      cnt_d   = cnt_q + 1'b1;
      end
`endif

      // Outputs are decoded from the next state so they leave a flop
      busy_d     = (state_d != IDLE);
      alu_en_d   = (state_d == EXEC);
      tx_valid_d = is_tx_state(state_d);
      unique case (state_d)
         TX_LO:   tx_data_d = res_d[DATA_WIDTH-1:0];
         TX_HI:   tx_data_d = res_d[RES_W-1:DATA_WIDTH];
         TX_ERR:  tx_data_d = ERR_BYTE;
         default: tx_data_d = '0;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         fun_q      <= '0;
         res_q      <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         alu_en_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         fun_q      <= fun_d;
         res_q      <= res_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         alu_en_q   <= alu_en_d;
         busy_q     <= busy_d;
      end
   end

`ifdef ALU_CMD_TIMEOUT_EN
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`endif

   assign bus.TX_DATA  = tx_data_q;
   assign bus.TX_VALID = tx_valid_q;
   assign bus.ALU_A    = a_q;
   assign bus.ALU_B    = b_q;
   assign bus.ALU_FUN  = fun_q;
   assign bus.ALU_EN   = alu_en_q;
   assign bus.BUSY     = busy_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: directed frames from the test plan plus random frames
// checked against a byte-level frame model and a 1-cycle-latency ALU stand-in.
module tb_alu_cmd_ctrl;
   import alu_sys_pkg::*;

   logic CLK = 1'b0;
   logic RST_n = 1'b0;
   always #5 CLK = ~CLK;

   alu_cmd_ctrl_if #(.DATA_WIDTH(8), .FUN_WIDTH(4)) bus ();

   alu_cmd_ctrl dut (
      .CLK   (CLK),
      .RST_n (RST_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int en_cnt = 0;
   logic [7:0] tx_q[$];
   int cyc_q[$];

   function automatic logic [15:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] f);
      case (f)
         FUN_ADD:   return 16'(a) + 16'(b);
         FUN_SUB:   return 16'(a) - 16'(b);
         FUN_MUL:   return 16'(a) * 16'(b);
         FUN_DIV:   return (b == 8'h0) ? 16'h0 : 16'(a / b);
         FUN_AND:   return {8'h0, a & b};
         FUN_OR:    return {8'h0, a | b};
         FUN_NAND:  return {8'h0, ~(a & b)};
         FUN_NOR:   return {8'h0, ~(a | b)};
         FUN_XOR:   return {8'h0, a ^ b};
         FUN_XNOR:  return {8'h0, ~(a ^ b)};
         FUN_CMPEQ: return (a == b) ? 16'd1 : 16'd0;
         FUN_CMPGT: return (a > b) ? 16'd1 : 16'd0;
         FUN_CMPLT: return (a < b) ? 16'd1 : 16'd0;
         FUN_SHR:   return {8'h0, a >> 1};
         FUN_SHL:   return 16'(a) << 1;
         default:   return 16'h0;
      endcase
   endfunction

   // ALU stand-in: registered result, valid only for supported codes, held between ops
   always @(posedge CLK) begin
      if (bus.ALU_EN) begin
         bus.ALU_OUT       <= ref_alu(bus.ALU_A, bus.ALU_B, bus.ALU_FUN);
         bus.ALU_OUT_VALID <= (bus.ALU_FUN != 4'hF);
      end
   end

   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (bus.ALU_EN) en_cnt <= en_cnt + 1;
      if (RST_n && bus.TX_VALID && bus.TX_READY) begin
         tx_q.push_back(bus.TX_DATA);
         cyc_q.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk(tag, 32'({bus.TX_DATA, bus.TX_VALID, bus.ALU_A, bus.ALU_B, bus.ALU_FUN,
                    bus.ALU_EN, bus.BUSY}), 32'h0);
   endtask

   task automatic model_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f,
                              output int n, output logic [7:0] e0, output logic [7:0] e1);
      logic [15:0] r;
      r = ref_alu(a, b, f[3:0]);
      if (f[7:4] != 4'h0 || f[3:0] == 4'hF) begin
         n = 1; e0 = ERR_BYTE; e1 = 8'h00;
      end else begin
         n = 2; e0 = r[7:0]; e1 = r[15:8];
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge CLK);
      bus.RX_DATA  = b;
      bus.RX_VALID = 1'b1;
      @(negedge CLK);
      bus.RX_VALID = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
      send_byte(CMD_ALU);
      send_byte(a);
      send_byte(b);
      send_byte(f);
   endtask

   task automatic wait_tx_valid();
      int t;
      t = 0;
      while (!bus.TX_VALID && t < 100) begin
         @(negedge CLK);
         t++;
      end
   endtask

   task automatic collect(input int n_exp, input int stall, input logic [7:0] e0,
                          input logic [7:0] e1, input string tag);
      int base, t;
      logic ok;
      base = tx_q.size();
      bus.TX_READY = 1'b0;
      wait_tx_valid();
      chk({tag, "/valid"}, 32'(bus.TX_VALID), 32'h1);
      ok = 1'b1;
      for (int i = 0; i < stall; i++) begin
         @(negedge CLK);
         if (bus.TX_VALID !== 1'b1 || bus.TX_DATA !== e0) ok = 1'b0;
      end
      if (stall > 0) chk({tag, "/hold"}, 32'(ok), 32'h1);
      bus.TX_READY = 1'b1;
      t = 0;
      while (tx_q.size() < base + n_exp && t < 100) begin
         @(negedge CLK);
         t++;
      end
      repeat (3) @(negedge CLK);
      bus.TX_READY = 1'b0;
      chk({tag, "/count"}, 32'(tx_q.size() - base), 32'(n_exp));
      if (tx_q.size() >= base + n_exp) begin
         chk({tag, "/b0"}, 32'(tx_q[base]), 32'(e0));
         if (n_exp == 2) begin
            chk({tag, "/b1"}, 32'(tx_q[base+1]), 32'(e1));
            chk({tag, "/gap"}, 32'(cyc_q[base+1] - cyc_q[base]), 32'h1);
         end
      end
      chk({tag, "/busy"}, 32'(bus.BUSY), 32'h0);
   endtask

   task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f,
                            input int stall, input int n_exp, input logic [7:0] e0,
                            input logic [7:0] e1, input int en_exp, input string tag);
      int eb;
      eb = en_cnt;
      send_frame(a, b, f);
      collect(n_exp, stall, e0, e1, tag);
      chk({tag, "/en"}, 32'(en_cnt - eb), 32'(en_exp));
   endtask

   initial begin
      int eb, base, n;
      logic [7:0] a, b, f, j, e0, e1;

      bus.RX_DATA  = 8'h00;
      bus.RX_VALID = 1'b0;
      bus.TX_READY = 1'b0;
      repeat (3) @(negedge CLK);
      chk_idle("reset_held");
      RST_n = 1'b1;
      repeat (2) @(negedge CLK);
      chk_idle("reset_released");

      run_frame(8'h1E, 8'h0F, 8'h02, 0, 2, 8'hC2, 8'h01, 1, "mul");
      run_frame(8'h05, 8'h14, 8'h04, 5, 2, 8'h04, 8'h00, 1, "and_stall");
      run_frame(8'h05, 8'h14, 8'h0F, 0, 1, 8'hEE, 8'h00, 1, "fun_unsup");
      run_frame(8'h05, 8'h14, 8'h12, 0, 1, 8'hEE, 8'h00, 0, "fun_hibits");

      // junk before the frame, CC inside the frame is operand B
      eb = en_cnt;
      send_byte(8'h55);
      send_byte(8'hCC);
      send_byte(8'h0A);
      send_byte(8'hCC);
      send_byte(8'h0D);
      wait_tx_valid();
      chk("shr/alu_a", 32'(bus.ALU_A), 32'h0A);
      chk("shr/alu_b", 32'(bus.ALU_B), 32'hCC);
      chk("shr/alu_fun", 32'(bus.ALU_FUN), 32'hD);
      collect(2, 0, 8'h05, 8'h00, "shr");
      chk("shr/en", 32'(en_cnt - eb), 32'h1);

      // reset in GET_B
      send_byte(8'hCC);
      send_byte(8'h11);
      @(negedge CLK);
      RST_n = 1'b0;
      #1;
      chk_idle("rst_get_b");
      @(negedge CLK);
      RST_n = 1'b1;
      run_frame(8'h07, 8'h03, 8'h00, 0, 2, 8'h0A, 8'h00, 1, "post_rst1");

      // reset in TX_HI
      send_frame(8'hFF, 8'hFF, 8'h00);
      bus.TX_READY = 1'b0;
      wait_tx_valid();
      chk("rst_tx/lo", 32'(bus.TX_DATA), 32'hFE);
      bus.TX_READY = 1'b1;
      @(negedge CLK);
      bus.TX_READY = 1'b0;
      chk("rst_tx/hi", 32'({bus.TX_VALID, bus.TX_DATA}), 32'h101);
      RST_n = 1'b0;
      #1;
      chk_idle("rst_tx_hi");
      @(negedge CLK);
      RST_n = 1'b1;
      run_frame(8'h09, 8'h03, 8'h01, 0, 2, 8'h06, 8'h00, 1, "post_rst2");

      // RX bytes during transmit are dropped
      send_frame(8'h02, 8'h03, 8'h02);
      bus.TX_READY = 1'b0;
      wait_tx_valid();
      send_byte(8'hCC);
      send_byte(8'h01);
      collect(2, 0, 8'h06, 8'h00, "drop");
      run_frame(8'h04, 8'h04, 8'h0A, 0, 2, 8'h01, 8'h00, 1, "cmpeq");

`ifdef ALU_CMD_TIMEOUT_EN
      eb = en_cnt;
      base = tx_q.size();
      send_byte(8'hCC);
      send_byte(8'h01);
      repeat (254) @(negedge CLK);
      send_byte(8'h02);
      send_byte(8'h00);
      repeat (5) @(negedge CLK);
      chk("timeout/tx", 32'(tx_q.size() - base), 32'h0);
      chk("timeout/busy", 32'(bus.BUSY), 32'h0);
      chk("timeout/en", 32'(en_cnt - eb), 32'h0);
      send_byte(8'hCC);
      send_byte(8'h01);
      repeat (253) @(negedge CLK);
      send_byte(8'h02);
      send_byte(8'h00);
      collect(2, 0, 8'h03, 8'h00, "gap254");
`else
      send_byte(8'hCC);
      send_byte(8'h01);
      repeat (299) @(negedge CLK);
      send_byte(8'h02);
      send_byte(8'h00);
      collect(2, 0, 8'h03, 8'h00, "long_gap");
`endif

      for (int i = 0; i < 24; i++) begin
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 5) == 0)
            f = {4'($urandom_range(1, 15)), 4'($urandom_range(0, 15))};
         else
            f = {4'h0, 4'($urandom_range(0, 15))};
         model_frame(a, b, f, n, e0, e1);
         if ($urandom_range(0, 1) == 1) begin
            j = 8'($urandom_range(0, 255));
            if (j == CMD_ALU) j = 8'h33;
            send_byte(j);
         end
         run_frame(a, b, f, int'($urandom_range(0, 3)), n, e0, e1,
                   (f[7:4] == 4'h0) ? 1 : 0, $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
- Command controller directly upstream and downstream of the ALU.
- Parses byte frames from the RX path (command 0xCC, operand A, operand B, function code).
- Drives the ALU operand, function and enable inputs, captures the registered ALU result, and returns it as two bytes (low byte, then high byte) over a valid/ready TX handshake.
- Single clock domain (CLK); sits between the RX-side synchroniser and the TX FIFO.

Parameters:
- DATA_WIDTH, 8, operand and byte width; ALU result width is 2*DATA_WIDTH.
- FUN_WIDTH, 4, width of the ALU function code.
- CMD_ALU, 8'hCC, frame start byte.
- ERR_BYTE, 8'hEE, byte returned for an invalid function code.
- TIMEOUT_CYCLES, 255, inter-byte timeout limit (used only with the optional feature).

Ports:
- CLK  in  1  clock.
- RST_n  in  1  reset, asynchronous, active-low.
- RX_DATA  in  DATA_WIDTH  received byte.
- RX_VALID  in  1  single-cycle strobe qualifying RX_DATA; no backpressure.
- TX_DATA  out  DATA_WIDTH  byte to the TX FIFO.
- TX_VALID  out  1  TX_DATA valid.
- TX_READY  in  1  consumer accepts the byte.
- ALU_A  out  DATA_WIDTH  operand A.
- ALU_B  out  DATA_WIDTH  operand B.
- ALU_FUN  out  FUN_WIDTH  function code.
- ALU_EN  out  1  ALU enable, single-cycle pulse.
- ALU_OUT  in  2*DATA_WIDTH  registered ALU result.
- ALU_OUT_VALID  in  1  ALU result valid.
- BUSY  out  1  high whenever state != IDLE.

Behaviour:
- Reset: state IDLE; TX_DATA, TX_VALID, ALU_A, ALU_B, ALU_FUN, ALU_EN, BUSY and the internal result register all 0.
- Reset asserted mid-frame or mid-transmit aborts immediately. The partial frame is discarded and TX_VALID drops.
- FSM states: IDLE, GET_A, GET_B, GET_FUN, EXEC, WAIT, TX_LO, TX_HI, TX_ERR.
- IDLE: an RX_VALID with RX_DATA==CMD_ALU goes to GET_A. Any other byte is ignored and the FSM stays in IDLE.
- GET_A: on RX_VALID, register ALU_A and go to GET_B.
- GET_B: on RX_VALID, register ALU_B and go to GET_FUN.
- GET_FUN: on RX_VALID, register ALU_FUN <= RX_DATA[FUN_WIDTH-1:0].
  - Upper bits RX_DATA[DATA_WIDTH-1:FUN_WIDTH] nonzero: go to TX_ERR with no ALU_EN pulse.
  - Otherwise go to EXEC.
- A CMD_ALU byte received inside GET_A/GET_B/GET_FUN is treated as data, not as a frame restart.
- EXEC: ALU_EN=1 for exactly this one cycle; next state WAIT. ALU_A, ALU_B and ALU_FUN stay stable from GET_FUN exit until IDLE is re-entered.
- WAIT (one cycle after EXEC; ALU latency is 1): sample ALU_OUT_VALID.
  - 1: latch ALU_OUT into the result register; go to TX_LO.
  - 0 (unsupported code such as 4'b1111): go to TX_ERR.
- TX_LO: TX_VALID=1, TX_DATA=result[DATA_WIDTH-1:0]. Hold both stable until TX_READY. On the TX_VALID&&TX_READY edge go to TX_HI.
- TX_HI: same handshake with result[2*DATA_WIDTH-1:DATA_WIDTH]; on acceptance go to IDLE.
- TX_ERR: same handshake with ERR_BYTE; on acceptance go to IDLE.
- TX_VALID never drops before acceptance. If TX_READY is held high, one byte is accepted per cycle, with no bubble between TX_LO and TX_HI.
- RX bytes arriving in EXEC/WAIT/TX_* are dropped. No buffering.
- ALU_OUT_VALID is ignored outside WAIT; the ALU holds a stale valid between operations.
- ALU_EN is registered (no combinational path from RX_VALID).

Optional Feature:
- Macro: ALU_CMD_TIMEOUT_EN.
- Defined:
  - A counter restarts on each accepted byte in GET_A/GET_B/GET_FUN and increments every cycle without RX_VALID.
  - When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE, the partial frame is discarded and nothing is transmitted.
  - RX_VALID in the same cycle as the limit is accepted (the byte wins).
- Undefined: no counter; a partial frame waits indefinitely.

Decomposition:
- Shared package alu_sys_pkg holds:
  - state enum/localparams;
  - CMD_ALU and ERR_BYTE constants;
  - ALU function code constants (ADD=0, SUB=1, MUL=2, DIV=3, AND=4 … SHL=14).
- No sub-module is needed. The timeout counter stays inline under the macro.

Test Plan:
- Frame CC,1E,0F,02 (30*15) -> one ALU_EN pulse; TX bytes C2 then 01 (450=0x01C2); BUSY low afterwards.
- Frame CC,05,14,04 with TX_READY held low for 5 cycles -> TX_VALID/TX_DATA=04 held stable for 5 cycles; then 04, 00.
- Frame CC,05,14,0F -> ALU_OUT_VALID=0 in WAIT -> single TX byte EE; frame CC,05,14,12 -> EE with no ALU_EN pulse.
- Bytes 55,CC,0A,CC,0D (0D=SHR): 55 ignored; second CC taken as operand B -> ALU_B=CC, ALU_A>>1 -> TX 05, 00.
- Reset pulsed during GET_B and again during TX_HI -> all outputs 0 and state IDLE; the next full frame is processed normally.
- With ALU_CMD_TIMEOUT_EN: CC,01 then 255 idle cycles -> return to IDLE, no TX; the same gap of 254 cycles -> frame completes.
